// File: rtl/vga_pkg.sv
// vga_pkg: shared constants and types for the VGA mode sequencer.
//   - cfg address map (table entries 0-3, control word 4, 5-7 reserved)
//   - cfg_data field positions for table entries and the control word
//   - table entry struct, FSM state encoding, frame-limit helper
package vga_pkg;

    localparam int unsigned NUM_ENTRIES = 4;

    // cfg address map
    localparam logic [2:0] CFG_ADDR_ENTRY_MAX = 3'd3;
    localparam logic [2:0] CFG_ADDR_CTRL      = 3'd4;

    // Table entry fields in cfg_data
    localparam int unsigned CFG_SPEED_LSB  = 10;
    localparam int unsigned CFG_MODE_LSB   = 8;
    localparam int unsigned CFG_FRAMES_LSB = 0;

    // Control word fields in cfg_data
    localparam int unsigned CTRL_LOOP_BIT = 2;
    localparam int unsigned CTRL_LAST_LSB = 0;

    typedef struct packed {
        logic [1:0] speed;
        logic [1:0] mode;
        logic [7:0] frames;
    } entry_t;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // Last frame_cnt value of an entry; frames=0 behaves like frames=1.
    function automatic logic [7:0] frame_limit(input logic [7:0] frames);
        return (frames == 8'd0) ? 8'd0 : frames - 8'd1;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: registers a level once and emits a registered one-cycle
// pulse in the cycle after a 0->1 transition was seen.
// Ports:
//   clk   - clock
//   rst_n - synchronous active-low reset
//   level - input level, synchronous to clk
//   rise  - registered rising-edge pulse
module sync_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic rise
);

    logic level_q;
    logic rise_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            level_q <= level;
            rise_q  <= level & ~level_q;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/vga_mode_sequencer.sv
// vga_mode_sequencer: steps through a 4-entry table of {speed, mode, frames},
// one step per frame, driving pattern mode and horizontal scroll.
// Ports:
//   clk, rst_n           - pixel clock, synchronous active-low reset
//   vsync                - vertical sync, frame_tick derived from its rising edge
//   enable               - sequencing runs while high, forces IDLE when low
//   cfg_valid/cfg_ready  - config write handshake (stalled only in the tick cycle)
//   cfg_addr/cfg_data    - pending-table write (0-3 entries, 4 control)
//   mode, scroll         - outputs to the colour datapath
//   entry_idx            - active table entry
//   frame_tick           - one-cycle pulse per frame
//   busy                 - high in RUN
module vga_mode_sequencer #(
    parameter int unsigned SCROLL_W = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                vsync,
    input  logic                enable,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [2:0]          cfg_addr,
    input  logic [11:0]         cfg_data,
    output logic [1:0]          mode,
    output logic [SCROLL_W-1:0] scroll,
    output logic [1:0]          entry_idx,
    output logic                frame_tick,
    output logic                busy
);

    import vga_pkg::*;

    state_e                state_q, state_d;
    logic [SCROLL_W-1:0]   scroll_q, scroll_d;
    logic [1:0]            idx_q, idx_d, idx_c;
    logic [7:0]            cnt_q, cnt_d, cnt_c;
    entry_t                pend_tbl_q [NUM_ENTRIES];
    entry_t                act_tbl_q  [NUM_ENTRIES];
    logic [1:0]            pend_last_q, act_last_q, last_c;
    logic                  pend_loop_q, act_loop_q, loop_c;
    logic                  dirty_q;
    logic                  commit;
    logic                  cfg_we;
    entry_t                cur_c;

    sync_edge_detect u_vsync_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .level (vsync),
        .rise  (frame_tick)
    );

    assign cfg_ready = ~frame_tick;
    assign cfg_we    = cfg_valid & cfg_ready;
    assign commit    = frame_tick & dirty_q;

    // Pending/active tables. A write can never coincide with a commit because
    // cfg_ready is low in the tick cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_tbl_q  <= '{default: '0};
            act_tbl_q   <= '{default: '0};
            pend_last_q <= 2'd0;
            act_last_q  <= 2'd0;
            pend_loop_q <= 1'b1;
            act_loop_q  <= 1'b1;
            dirty_q     <= 1'b0;
        end else begin
            if (cfg_we) begin
                if (cfg_addr <= CFG_ADDR_ENTRY_MAX) begin
                    pend_tbl_q[cfg_addr[1:0]] <= '{
                        speed:  cfg_data[CFG_SPEED_LSB +: 2],
                        mode:   cfg_data[CFG_MODE_LSB +: 2],
                        frames: cfg_data[CFG_FRAMES_LSB +: 8]
                    };
                    dirty_q <= 1'b1;
                end else if (cfg_addr == CFG_ADDR_CTRL) begin
                    pend_last_q <= cfg_data[CTRL_LAST_LSB +: 2];
                    pend_loop_q <= cfg_data[CTRL_LOOP_BIT];
                    dirty_q     <= 1'b1;
                end
            end
            if (commit) begin
                act_tbl_q  <= pend_tbl_q;
                act_last_q <= pend_last_q;
                act_loop_q <= pend_loop_q;
                dirty_q    <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            scroll_q <= '0;
            idx_q    <= 2'd0;
            cnt_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            scroll_q <= scroll_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        scroll_d = scroll_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;

        // A commit in this cycle governs this frame's advance, so evaluate
        // against the table that is about to become active.
        last_c = commit ? pend_last_q : act_last_q;
        loop_c = commit ? pend_loop_q : act_loop_q;
        idx_c  = idx_q;
        cnt_c  = cnt_q;
        if (commit && (idx_q > pend_last_q)) begin
            idx_c = 2'd0;
            cnt_c = 8'd0;
        end
        cur_c = commit ? pend_tbl_q[idx_c] : act_tbl_q[idx_c];

        case (state_q)
            StIdle: begin
                idx_d = 2'd0;
                cnt_d = 8'd0;
                if (frame_tick && enable) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (frame_tick) begin
                    scroll_d = scroll_q + SCROLL_W'(cur_c.speed);
                    idx_d    = idx_c;
                    if (cnt_c == frame_limit(cur_c.frames)) begin
                        cnt_d = 8'd0;
                        if (idx_c == last_c) begin
                            if (loop_c) begin
                                idx_d = 2'd0;
                            end else begin
                                state_d = StDone;
                            end
                        end else begin
                            idx_d = idx_c + 2'd1;
                        end
                    end else begin
                        cnt_d = cnt_c + 8'd1;
                    end
                end
            end
            StDone: begin
                if (commit) begin
                    state_d = StRun;
                    idx_d   = 2'd0;
                    cnt_d   = 8'd0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (!enable) begin
            state_d = StIdle;
            idx_d   = 2'd0;
            cnt_d   = 8'd0;
        end
    end

    assign mode      = (state_q == StIdle) ? 2'd0 : act_tbl_q[idx_q].mode;
    assign busy      = (state_q == StRun);
    assign scroll    = scroll_q;
    assign entry_idx = idx_q;

endmodule

// File: tb/tb_vga_mode_sequencer.sv
// tb_vga_mode_sequencer: directed self-checking bench for vga_mode_sequencer.
module tb_vga_mode_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vsync;
    logic        enable;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [2:0]  cfg_addr;
    logic [11:0] cfg_data;
    logic [1:0]  mode;
    logic [9:0]  scroll;
    logic [1:0]  entry_idx;
    logic        frame_tick;
    logic        busy;

    int          checks = 0;
    int          errors = 0;
    logic [1:0]  tick_mode;

    vga_mode_sequencer #(.SCROLL_W(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .vsync      (vsync),
        .enable     (enable),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .mode       (mode),
        .scroll     (scroll),
        .entry_idx  (entry_idx),
        .frame_tick (frame_tick),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    // All tasks are entered and left 1 time unit after a rising edge.
    task automatic do_reset();
        rst_n = 1'b0; vsync = 1'b0; enable = 1'b0;
        cfg_valid = 1'b0; cfg_addr = 3'd0; cfg_data = 12'd0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [11:0] d);
        cfg_valid = 1'b1; cfg_addr = a; cfg_data = d;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
    endtask

    // One vsync pulse; tick_mode is the mode seen during the tick cycle,
    // i.e. the entry governing this frame's advance.
    task automatic run_frame();
        vsync = 1'b1;
        @(posedge clk); #1;
        tick_mode = mode;
        checks++;
        if (frame_tick !== 1'b1) begin
            errors++; $display("FAIL frame_tick_high: got %b want 1", frame_tick);
        end
        @(posedge clk); #1;
        vsync = 1'b0;
        checks++;
        if (frame_tick !== 1'b0) begin
            errors++; $display("FAIL frame_tick_pulse: got %b want 0", frame_tick);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; vsync = 1'b0; enable = 1'b0;
        cfg_valid = 1'b0; cfg_addr = 3'd0; cfg_data = 12'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (scroll !== 10'd0) begin errors++; $display("FAIL rst_scroll: got %0d want 0", scroll); end
        checks++; if (mode !== 2'd0) begin errors++; $display("FAIL rst_mode: got %0d want 0", mode); end
        checks++; if (entry_idx !== 2'd0) begin errors++; $display("FAIL rst_idx: got %0d want 0", entry_idx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL rst_tick: got %b want 0", frame_tick); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", cfg_ready); end
    endtask

    task automatic test_idle_run();
        enable = 1'b1;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_wait: got busy %b want 0", busy); end
        run_frame();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL idle_to_run: got busy %b want 1", busy); end
        checks++; if (mode !== 2'd0) begin errors++; $display("FAIL run_mode0: got %0d want 0", mode); end
        repeat (2) run_frame();
        checks++; if (scroll !== 10'd0) begin errors++; $display("FAIL speed0_scroll: got %0d want 0", scroll); end
    endtask

    task automatic test_sequence_loop();
        logic [1:0] exp_mode [6];
        logic [9:0] exp_scroll [6];
        exp_mode   = '{2'd1, 2'd1, 2'd2, 2'd1, 2'd1, 2'd2};
        exp_scroll = '{10'd1, 10'd2, 10'd5, 10'd6, 10'd7, 10'd10};
        enable = 1'b0;
        @(posedge clk); #1;
        cfg_write(3'd0, 12'h502);
        cfg_write(3'd1, 12'hE01);
        cfg_write(3'd4, 12'h005);
        enable = 1'b1;
        run_frame();
        for (int i = 0; i < 6; i++) begin
            run_frame();
            checks++;
            if (tick_mode !== exp_mode[i]) begin
                errors++; $display("FAIL loop_mode[%0d]: got %0d want %0d", i, tick_mode, exp_mode[i]);
            end
            checks++;
            if (scroll !== exp_scroll[i]) begin
                errors++; $display("FAIL loop_scroll[%0d]: got %0d want %0d", i, scroll, exp_scroll[i]);
            end
        end
        repeat (2) run_frame();
        checks++; if (scroll !== 10'd12) begin errors++; $display("FAIL loop_scroll8: got %0d want 12", scroll); end
        checks++; if (entry_idx !== 2'd1) begin errors++; $display("FAIL loop_idx8: got %0d want 1", entry_idx); end
    endtask

    task automatic test_enable_drop();
        enable = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_busy: got %b want 0", busy); end
        checks++; if (mode !== 2'd0) begin errors++; $display("FAIL drop_mode: got %0d want 0", mode); end
        checks++; if (entry_idx !== 2'd0) begin errors++; $display("FAIL drop_idx: got %0d want 0", entry_idx); end
        checks++; if (scroll !== 10'd12) begin errors++; $display("FAIL drop_scroll: got %0d want 12", scroll); end
        enable = 1'b1;
        run_frame();
        run_frame();
        checks++; if (scroll !== 10'd13) begin errors++; $display("FAIL rerun_scroll: got %0d want 13", scroll); end
        checks++; if (mode !== 2'd1) begin errors++; $display("FAIL rerun_mode: got %0d want 1", mode); end
    endtask

    task automatic test_reset_mid_run();
        vsync = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++; if (scroll !== 10'd0) begin errors++; $display("FAIL midrst_scroll: got %0d want 0", scroll); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
        checks++; if (mode !== 2'd0) begin errors++; $display("FAIL midrst_mode: got %0d want 0", mode); end
        checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL midrst_tick: got %b want 0", frame_tick); end
        // vsync still high: a cleared vsync register sees a fresh rising edge.
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (frame_tick !== 1'b1) begin errors++; $display("FAIL midrst_vsreg: got %b want 1", frame_tick); end
        vsync = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_sequence_once();
        do_reset();
        cfg_write(3'd0, 12'h502);
        cfg_write(3'd1, 12'hE01);
        cfg_write(3'd4, 12'h001);
        enable = 1'b1;
        run_frame();
        repeat (3) run_frame();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL done_busy: got %b want 0", busy); end
        checks++; if (mode !== 2'd2) begin errors++; $display("FAIL done_mode: got %0d want 2", mode); end
        checks++; if (scroll !== 10'd5) begin errors++; $display("FAIL done_scroll: got %0d want 5", scroll); end
        run_frame();
        checks++; if (scroll !== 10'd5) begin errors++; $display("FAIL done_frozen: got %0d want 5", scroll); end
        checks++; if (entry_idx !== 2'd1) begin errors++; $display("FAIL done_idx: got %0d want 1", entry_idx); end
        cfg_write(3'd4, 12'h005);
        run_frame();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL done_rerun: got busy %b want 1", busy); end
        checks++; if (entry_idx !== 2'd0) begin errors++; $display("FAIL done_rerun_idx: got %0d want 0", entry_idx); end
    endtask

    task automatic test_cfg_handshake();
        do_reset();
        cfg_write(3'd0, 12'h101);
        cfg_write(3'd1, 12'h201);
        cfg_write(3'd4, 12'h005);
        cfg_write(3'd5, 12'hFFF);
        enable = 1'b1;
        run_frame();
        vsync = 1'b1;
        @(posedge clk); #1;
        cfg_valid = 1'b1; cfg_addr = 3'd1; cfg_data = 12'h001;
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL hs_ready_tick: got %b want 0", cfg_ready); end
        @(posedge clk); #1;
        vsync = 1'b0;
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL hs_ready_after: got %b want 1", cfg_ready); end
        checks++; if (entry_idx !== 2'd1) begin errors++; $display("FAIL hs_idx: got %0d want 1", entry_idx); end
        cfg_addr = 3'd0; cfg_data = 12'h301;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        @(posedge clk); #1;
        run_frame();
        checks++; if (mode !== 2'd3) begin errors++; $display("FAIL hs_accepted: got %0d want 3", mode); end
        run_frame();
        checks++; if (mode !== 2'd2) begin errors++; $display("FAIL hs_tick_blocked: got %0d want 2", mode); end
    endtask

    task automatic test_scroll_wrap();
        do_reset();
        enable = 1'b1;
        cfg_write(3'd0, 12'hC01);
        cfg_write(3'd4, 12'h004);
        run_frame();
        repeat (340) run_frame();
        checks++; if (scroll !== 10'd1020) begin errors++; $display("FAIL wrap_pre: got %0d want 1020", scroll); end
        cfg_write(3'd0, 12'h401);
        run_frame();
        checks++; if (scroll !== 10'd1021) begin errors++; $display("FAIL commit_same_tick: got %0d want 1021", scroll); end
        run_frame();
        checks++; if (scroll !== 10'd1022) begin errors++; $display("FAIL wrap_1022: got %0d want 1022", scroll); end
        cfg_write(3'd0, 12'hC01);
        run_frame();
        checks++; if (scroll !== 10'd1) begin errors++; $display("FAIL wrap: got %0d want 1", scroll); end
    endtask

    initial begin
        test_reset();
        test_idle_run();
        test_sequence_loop();
        test_enable_drop();
        test_reset_mid_run();
        test_sequence_once();
        test_cfg_handshake();
        test_scroll_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
